// File: rtl/controladora_multicanal_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : controladora_pkg
//  Purpose  : Shared state encodings and decode helpers for the multi-channel
//             lamp controller.
//  Contents : estado_lampada_t, estado_botao_t, lamp_acesa(), modo_manual()
//  Revision : 1.0 - initial release
// ============================================================================
package controladora_pkg;

    typedef enum logic [1:0] {
        DES_AUTO = 2'd0,
        LIG_AUTO = 2'd1,
        DES_MAN  = 2'd2,
        LIG_MAN  = 2'd3
    } estado_lampada_t;

    typedef enum logic [1:0] {
        B_IDLE     = 2'd0,
        B_HOLD     = 2'd1,
        B_WAIT_REL = 2'd2
    } estado_botao_t;

    // Lamp is driven in both "lit" states, whatever the mode.
    function automatic logic lamp_acesa(input estado_lampada_t estado);
        return (estado == LIG_AUTO) || (estado == LIG_MAN);
    endfunction

    function automatic logic modo_manual(input estado_lampada_t estado);
        return (estado == DES_MAN) || (estado == LIG_MAN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/controladora_multicanal_if.sv
`default_nettype none
// ============================================================================
//  Module   : controladora_multicanal_if
//  Purpose  : Per-channel button/sensor inputs and lamp/LED/timeout outputs.
//  Ports    : push_button, infravermelho (to controller)
//             saida, led, desligou       (from controller)
//  Modports : master - environment side, slave - controller side
//  Revision : 1.0 - initial release
// ============================================================================
interface controladora_multicanal_if #(
    parameter int N_CH = 4
) ();

    logic [N_CH-1:0] push_button;
    logic [N_CH-1:0] infravermelho;
    logic [N_CH-1:0] saida;
    logic [N_CH-1:0] led;
    logic [N_CH-1:0] desligou;

    modport master (
        output push_button,
        output infravermelho,
        input  saida,
        input  led,
        input  desligou
    );

    modport slave (
        input  push_button,
        input  infravermelho,
        output saida,
        output led,
        output desligou
    );

endinterface
`default_nettype wire

// File: rtl/controladora_multicanal_canal_lampada.sv
`default_nettype none
// ============================================================================
//  Module   : canal_lampada
//  Purpose  : One lamp channel: input synchronizers, button debounce,
//             short/long press classifier and auto/manual lamp FSM.
//  Ports    : clk, rst_n (async, active-low)
//             push_button, infravermelho : raw asynchronous inputs
//             saida    : lamp drive       led : manual-mode indicator
//             desligou : one-cycle pulse on auto timeout
//  Revision : 1.0 - initial release
// ============================================================================
module canal_lampada
    import controladora_pkg::*;
#(
    parameter int DEBOUNCE_P        = 300,
    parameter int SWITCH_MODE_MIN_T = 5000,
    parameter int AUTO_SHUTDOWN_T   = 30000
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  push_button,
    input  wire  infravermelho,
    output logic saida,
    output logic led,
    output logic desligou
);

    localparam int W_DB   = $clog2(DEBOUNCE_P + 1);
    localparam int W_HOLD = $clog2(SWITCH_MODE_MIN_T + 1);
    localparam int W_IDLE = $clog2(AUTO_SHUTDOWN_T + 1);

    localparam logic [W_DB-1:0]   c_DB_LAST   = W_DB'(DEBOUNCE_P - 1);
    localparam logic [W_DB-1:0]   c_DB_MAX    = W_DB'(DEBOUNCE_P);
    localparam logic [W_HOLD-1:0] c_HOLD_LAST = W_HOLD'(SWITCH_MODE_MIN_T - 1);
    localparam logic [W_HOLD-1:0] c_HOLD_MAX  = W_HOLD'(SWITCH_MODE_MIN_T);
    localparam logic [W_IDLE-1:0] c_IDLE_LAST = W_IDLE'(AUTO_SHUTDOWN_T - 1);
    localparam logic [W_IDLE-1:0] c_IDLE_MAX  = W_IDLE'(AUTO_SHUTDOWN_T);

    logic            r_pb_meta, r_pb_s, r_ir_meta, r_ir_s;
    logic            r_pb_db;
    logic [W_DB-1:0] r_db_cnt;

    estado_botao_t     r_estado_botao, w_estado_botao_nxt;
    logic [W_HOLD-1:0] r_hold_cnt, w_hold_cnt_nxt;
    logic              r_curto, r_longo, w_curto_nxt, w_longo_nxt;

    estado_lampada_t   r_estado_lampada, w_estado_lampada_nxt;
    logic [W_IDLE-1:0] r_idle_cnt, w_idle_cnt_nxt;
    logic              r_desligou, w_desligou_nxt;

    // Two-flop synchronizers; IR goes downstream undebounced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pb_meta <= 1'b0;
            r_pb_s    <= 1'b0;
            r_ir_meta <= 1'b0;
            r_ir_s    <= 1'b0;
        end else begin
            r_pb_meta <= push_button;
            r_pb_s    <= r_pb_meta;
            r_ir_meta <= infravermelho;
            r_ir_s    <= r_ir_meta;
        end
    end

    // Debounce: accept the new level on the DEBOUNCE_P-th consecutive cycle
    // of disagreement; any agreeing cycle restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pb_db  <= 1'b0;
            r_db_cnt <= '0;
        end else if (r_pb_s != r_pb_db) begin
            if (r_db_cnt == c_DB_LAST) begin
                r_pb_db  <= r_pb_s;
                r_db_cnt <= '0;
            end else if (r_db_cnt != c_DB_MAX) begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end else begin
            r_db_cnt <= '0;
        end
    end

    // Press classifier: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado_botao <= B_IDLE;
            r_hold_cnt     <= '0;
            r_curto        <= 1'b0;
            r_longo        <= 1'b0;
        end else begin
            r_estado_botao <= w_estado_botao_nxt;
            r_hold_cnt     <= w_hold_cnt_nxt;
            r_curto        <= w_curto_nxt;
            r_longo        <= w_longo_nxt;
        end
    end

    // Press classifier: release wins over the long threshold in the same cycle.
    always_comb begin
        w_estado_botao_nxt = r_estado_botao;
        w_hold_cnt_nxt     = r_hold_cnt;
        w_curto_nxt        = 1'b0;
        w_longo_nxt        = 1'b0;
        case (r_estado_botao)
            B_IDLE: begin
                if (r_pb_db) begin
                    w_estado_botao_nxt = B_HOLD;
                    w_hold_cnt_nxt     = '0;
                end
            end
            B_HOLD: begin
                if (!r_pb_db) begin
                    w_curto_nxt        = 1'b1;
                    w_estado_botao_nxt = B_IDLE;
                end else if (r_hold_cnt == c_HOLD_LAST) begin
                    w_longo_nxt        = 1'b1;
                    w_estado_botao_nxt = B_WAIT_REL;
                end else if (r_hold_cnt != c_HOLD_MAX) begin
                    w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                end
            end
            B_WAIT_REL: begin
                if (!r_pb_db) begin
                    w_estado_botao_nxt = B_IDLE;
                end
            end
            default: begin
                w_estado_botao_nxt = B_IDLE;
            end
        endcase
    end

    // Lamp FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado_lampada <= DES_AUTO;
            r_idle_cnt       <= '0;
            r_desligou       <= 1'b0;
        end else begin
            r_estado_lampada <= w_estado_lampada_nxt;
            r_idle_cnt       <= w_idle_cnt_nxt;
            r_desligou       <= w_desligou_nxt;
        end
    end

    // Lamp FSM: longo beats curto beats IR/timeout. A short press in an auto
    // state is simply ignored, so the IR rules still apply that cycle.
    always_comb begin
        w_estado_lampada_nxt = r_estado_lampada;
        w_idle_cnt_nxt       = r_idle_cnt;
        w_desligou_nxt       = 1'b0;
        case (r_estado_lampada)
            DES_AUTO: begin
                if (r_longo) begin
                    w_estado_lampada_nxt = DES_MAN;
                    w_idle_cnt_nxt       = '0;
                end else if (r_ir_s) begin
                    w_estado_lampada_nxt = LIG_AUTO;
                    w_idle_cnt_nxt       = '0;
                end
            end
            LIG_AUTO: begin
                if (r_longo) begin
                    w_estado_lampada_nxt = DES_MAN;
                    w_idle_cnt_nxt       = '0;
                end else if (r_ir_s) begin
                    w_idle_cnt_nxt = '0;
                end else if (r_idle_cnt == c_IDLE_LAST) begin
                    w_estado_lampada_nxt = DES_AUTO;
                    w_idle_cnt_nxt       = '0;
                    w_desligou_nxt       = 1'b1;
                end else if (r_idle_cnt != c_IDLE_MAX) begin
                    w_idle_cnt_nxt = r_idle_cnt + 1'b1;
                end
            end
            DES_MAN: begin
                w_idle_cnt_nxt = '0;
                if (r_longo) begin
                    w_estado_lampada_nxt = DES_AUTO;
                end else if (r_curto) begin
                    w_estado_lampada_nxt = LIG_MAN;
                end
            end
            LIG_MAN: begin
                w_idle_cnt_nxt = '0;
                if (r_longo) begin
                    w_estado_lampada_nxt = DES_AUTO;
                end else if (r_curto) begin
                    w_estado_lampada_nxt = DES_MAN;
                end
            end
            default: begin
                w_estado_lampada_nxt = DES_AUTO;
                w_idle_cnt_nxt       = '0;
            end
        endcase
    end

    assign saida    = lamp_acesa(r_estado_lampada);
    assign led      = modo_manual(r_estado_lampada);
    assign desligou = r_desligou;

endmodule
`default_nettype wire

// File: rtl/controladora_multicanal.sv
`default_nettype none
// ============================================================================
//  Module   : controladora_multicanal
//  Purpose  : N_CH independent lamp channels, each with its own button,
//             IR sensor, lamp output, mode LED and timeout pulse.
//  Ports    : clk, rst_n (async, active-low)
//             bus (slave) : push_button, infravermelho in;
//                           saida, led, desligou out (N_CH bits each)
//  Revision : 1.0 - initial release
// ============================================================================
module controladora_multicanal
    import controladora_pkg::*;
#(
    parameter int N_CH              = 4,
    parameter int DEBOUNCE_P        = 300,
    parameter int SWITCH_MODE_MIN_T = 5000,
    parameter int AUTO_SHUTDOWN_T   = 30000
) (
    input  wire                      clk,
    input  wire                      rst_n,
    controladora_multicanal_if.slave bus
);

    logic [N_CH-1:0] w_saida;
    logic [N_CH-1:0] w_led;
    logic [N_CH-1:0] w_desligou;

    for (genvar i = 0; i < N_CH; i++) begin : g_canal
        canal_lampada #(
            .DEBOUNCE_P        (DEBOUNCE_P),
            .SWITCH_MODE_MIN_T (SWITCH_MODE_MIN_T),
            .AUTO_SHUTDOWN_T   (AUTO_SHUTDOWN_T)
        ) u_canal (
            .clk           (clk),
            .rst_n         (rst_n),
            .push_button   (bus.push_button[i]),
            .infravermelho (bus.infravermelho[i]),
            .saida         (w_saida[i]),
            .led           (w_led[i]),
            .desligou      (w_desligou[i])
        );
    end

    assign bus.saida    = w_saida;
    assign bus.led      = w_led;
    assign bus.desligou = w_desligou;

endmodule
`default_nettype wire

// File: tb/tb_controladora_multicanal.sv
`default_nettype none
// ============================================================================
//  Module   : tb_controladora_multicanal
//  Purpose  : Self-checking bench for controladora_multicanal (2 channels).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_controladora_multicanal;

    localparam int N_CH              = 2;
    localparam int DEBOUNCE_P        = 4;
    localparam int SWITCH_MODE_MIN_T = 20;
    localparam int AUTO_SHUTDOWN_T   = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    controladora_multicanal_if #(.N_CH(N_CH)) bus ();

    controladora_multicanal #(
        .N_CH              (N_CH),
        .DEBOUNCE_P        (DEBOUNCE_P),
        .SWITCH_MODE_MIN_T (SWITCH_MODE_MIN_T),
        .AUTO_SHUTDOWN_T   (AUTO_SHUTDOWN_T)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] dut_vec();
        return {bus.desligou, bus.led, bus.saida};
    endfunction

    // ------------------------------------------------------------------
    // Reference model: time-stamp view of each channel. A level is
    // accepted after P cycles of disagreement, a press is long when it
    // lasts SW cycles, an auto lamp dies T cycles after IR was last seen.
    // ------------------------------------------------------------------
    bit m_meta_pb [N_CH], m_s_pb [N_CH], m_meta_ir [N_CH], m_s_ir [N_CH];
    bit m_db [N_CH], m_press [N_CH], m_long_done [N_CH];
    bit m_short [N_CH], m_long [N_CH];
    bit m_manual [N_CH], m_on [N_CH], m_des [N_CH];
    int m_last_eq [N_CH], m_t_start [N_CH], m_last_ir [N_CH];
    int m_edge = 0;

    task automatic model_reset();
        for (int ch = 0; ch < N_CH; ch++) begin
            m_meta_pb[ch] = 0; m_s_pb[ch] = 0; m_meta_ir[ch] = 0; m_s_ir[ch] = 0;
            m_db[ch] = 0; m_press[ch] = 0; m_long_done[ch] = 0;
            m_short[ch] = 0; m_long[ch] = 0;
            m_manual[ch] = 0; m_on[ch] = 0; m_des[ch] = 0;
            m_last_eq[ch] = m_edge; m_t_start[ch] = m_edge; m_last_ir[ch] = m_edge;
        end
    endtask

    task automatic model_step(input logic [N_CH-1:0] pb, input logic [N_CH-1:0] ir);
        m_edge++;
        for (int ch = 0; ch < N_CH; ch++) begin
            bit s_pb, s_ir, db, sh, lg;
            s_pb = m_s_pb[ch]; s_ir = m_s_ir[ch]; db = m_db[ch];
            sh = m_short[ch];  lg = m_long[ch];
            m_s_pb[ch] = m_meta_pb[ch]; m_meta_pb[ch] = pb[ch];
            m_s_ir[ch] = m_meta_ir[ch]; m_meta_ir[ch] = ir[ch];
            if (s_pb == db) m_last_eq[ch] = m_edge;
            else if (m_edge - m_last_eq[ch] >= DEBOUNCE_P) begin
                m_db[ch] = s_pb;
                m_last_eq[ch] = m_edge;
            end
            m_short[ch] = 0; m_long[ch] = 0;
            if (!m_press[ch]) begin
                if (db) begin m_press[ch] = 1; m_t_start[ch] = m_edge; m_long_done[ch] = 0; end
            end else if (!m_long_done[ch]) begin
                if (!db) begin m_short[ch] = 1; m_press[ch] = 0; end
                else if (m_edge - m_t_start[ch] >= SWITCH_MODE_MIN_T) begin
                    m_long[ch] = 1; m_long_done[ch] = 1;
                end
            end else if (!db) m_press[ch] = 0;
            m_des[ch] = 0;
            if (lg) begin
                m_manual[ch] = !m_manual[ch];
                m_on[ch] = 0;
            end else if (m_manual[ch]) begin
                if (sh) m_on[ch] = !m_on[ch];
            end else if (!m_on[ch]) begin
                if (s_ir) begin m_on[ch] = 1; m_last_ir[ch] = m_edge; end
            end else if (s_ir) m_last_ir[ch] = m_edge;
            else if (m_edge - m_last_ir[ch] >= AUTO_SHUTDOWN_T) begin
                m_on[ch] = 0; m_des[ch] = 1;
            end
        end
    endtask

    function automatic logic [5:0] model_vec();
        logic [5:0] v;
        v = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            v[ch] = m_on[ch]; v[N_CH+ch] = m_manual[ch]; v[2*N_CH+ch] = m_des[ch];
        end
        return v;
    endfunction

    // One clock: drive at negedge, model follows the posedge, compare at negedge.
    task automatic tick(input logic [1:0] pb, input logic [1:0] ir);
        bus.push_button   = pb;
        bus.infravermelho = ir;
        @(posedge clk);
        model_step(pb, ir);
        @(negedge clk);
        check("model", {26'd0, dut_vec()}, {26'd0, model_vec()});
    endtask

    // Asynchronous reset asserted between edges, outputs checked before any edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 check("async_reset", {26'd0, dut_vec()}, 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        string      name;
        logic [1:0] pb;
        logic [1:0] ir;
        int         n;
        logic [1:0] saida;
        logic [1:0] led;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int fall, des, des_at, other, hit;

        vecs[0]  = '{"idle",            2'b00, 2'b00,  4, 2'b00, 2'b00};
        vecs[1]  = '{"ir_both_on",      2'b00, 2'b11,  4, 2'b11, 2'b00};
        vecs[2]  = '{"ir1_timeout",     2'b00, 2'b01, 20, 2'b01, 2'b00};
        vecs[3]  = '{"ir0_timeout",     2'b00, 2'b00, 20, 2'b00, 2'b00};
        vecs[4]  = '{"long_pb0",        2'b01, 2'b00, 30, 2'b00, 2'b01};
        vecs[5]  = '{"long_release",    2'b00, 2'b00, 10, 2'b00, 2'b01};
        vecs[6]  = '{"short_hold",      2'b01, 2'b00,  8, 2'b00, 2'b01};
        vecs[7]  = '{"short_release",   2'b00, 2'b00, 10, 2'b01, 2'b01};
        vecs[8]  = '{"manual_vs_ir",    2'b00, 2'b11,  5, 2'b11, 2'b01};
        vecs[9]  = '{"manual_keeps_on", 2'b00, 2'b00, 20, 2'b01, 2'b01};
        vecs[10] = '{"long_back_auto",  2'b01, 2'b00, 30, 2'b00, 2'b00};
        vecs[11] = '{"back_release",    2'b00, 2'b00, 10, 2'b00, 2'b00};

        rst_n = 1'b0;
        bus.push_button   = '0;
        bus.infravermelho = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_state", {26'd0, dut_vec()}, 32'd0);

        // Steady-state vectors with hand-derived expectations
        foreach (vecs[k]) begin
            repeat (vecs[k].n) tick(vecs[k].pb, vecs[k].ir);
            check(vecs[k].name, {28'd0, bus.led, bus.saida}, {28'd0, vecs[k].led, vecs[k].saida});
        end

        // Reset mid-operation with lamps lit, then IR latency
        repeat (5) tick(2'b00, 2'b11);
        check("lamps_lit", {30'd0, bus.saida}, 32'd3);
        bus.infravermelho = '0;
        do_reset();
        tick(2'b00, 2'b01);
        tick(2'b00, 2'b01);
        check("ir_rise_early", {31'd0, bus.saida[0]}, 32'd0);
        tick(2'b00, 2'b01);
        check("ir_rise_3cyc", {31'd0, bus.saida[0]}, 32'd1);

        // Auto timeout measured from the raw fall
        repeat (7) tick(2'b00, 2'b01);
        fall = 0; des = 0; des_at = 0; other = 0;
        for (int k = 1; k <= 30; k++) begin
            tick(2'b00, 2'b00);
            if (fall == 0 && !bus.saida[0]) fall = k;
            if (bus.desligou[0]) begin des++; des_at = k; end
            other |= int'(bus.saida[1] | bus.led[1] | bus.desligou[1]);
        end
        check("timeout_fall", fall, 18);
        check("timeout_pulses", des, 1);
        check("timeout_pulse_at", des_at, 18);
        check("ch1_untouched", other, 0);

        // IR retrigger restarts the idle time
        repeat (5) tick(2'b00, 2'b01);
        des = 0;
        for (int k = 0; k < 10; k++) begin
            tick(2'b00, 2'b00);
            des += int'(bus.desligou[0]);
        end
        check("retrig_no_early_pulse", des, 0);
        check("retrig_still_on", {31'd0, bus.saida[0]}, 32'd1);
        tick(2'b00, 2'b01);
        fall = 0;
        for (int k = 1; k <= 30; k++) begin
            tick(2'b00, 2'b00);
            if (fall == 0 && !bus.saida[0]) fall = k;
            des += int'(bus.desligou[0]);
        end
        check("retrig_fall", fall, 18);
        check("retrig_pulses", des, 1);

        // Long press on channel 1
        hit = 0;
        for (int k = 1; k <= 40; k++) begin
            tick(2'b10, 2'b00);
            if (hit == 0 && bus.led[1]) hit = k;
        end
        check("long_latency", hit, 28);
        check("long_lamp_off", {31'd0, bus.saida[1]}, 32'd0);
        repeat (15) tick(2'b00, 2'b00);
        check("long_release_led", {31'd0, bus.led[1]}, 32'd1);
        check("long_release_no_toggle", {31'd0, bus.saida[1]}, 32'd0);

        // Short presses in manual mode, then in auto mode
        repeat (8) tick(2'b10, 2'b00);
        hit = 0;
        for (int k = 1; k <= 15; k++) begin
            tick(2'b00, 2'b00);
            if (hit == 0 && bus.saida[1]) hit = k;
        end
        check("short_on_latency", hit, 8);
        repeat (8) tick(2'b10, 2'b00);
        hit = 0;
        for (int k = 1; k <= 15; k++) begin
            tick(2'b00, 2'b00);
            if (hit == 0 && !bus.saida[1]) hit = k;
        end
        check("short_off_latency", hit, 8);
        repeat (40) tick(2'b10, 2'b00);
        repeat (15) tick(2'b00, 2'b00);
        check("back_to_auto", {31'd0, bus.led[1]}, 32'd0);
        repeat (8) tick(2'b10, 2'b00);
        repeat (15) tick(2'b00, 2'b00);
        check("short_in_auto", {30'd0, bus.led[1], bus.saida[1]}, 32'd0);

        // Bounce rejection on channel 0
        other = 0;
        for (int k = 0; k < 30; k++) begin
            tick({1'b0, (k % 4) < 2}, 2'b00);
            other |= int'(dut_vec() != 6'd0);
        end
        check("bounce_no_activity", other, 0);

        // Randomized stimulus against the model
        for (int seg = 0; seg < 160; seg++) begin
            logic [1:0] pb, ir;
            int len;
            if ($urandom_range(0, 39) == 0) do_reset();
            pb  = 2'($urandom);
            ir  = 2'($urandom);
            len = $urandom_range(1, 45);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 9) == 0) ir = ir ^ 2'($urandom_range(1, 3));
                tick(pb, ir);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/controladora_multicanal.md
Name: controladora_multicanal

Overview:
- N-channel successor to the single-lamp controller.
- Each channel has its own push button and IR presence sensor, and drives its own lamp output and manual-mode LED.
- Button presses are debounced on-chip and classified as short (toggle lamp in manual mode) or long (switch auto/manual mode).
- In auto mode the IR sensor turns the lamp on, and a per-channel idle timer turns it off after a timeout.

Parameters:
- N_CH, 4, number of independent lamp channels (1..16).
- DEBOUNCE_P, 300, consecutive stable cycles required to accept a button level change (>=2).
- SWITCH_MODE_MIN_T, 5000, debounced hold cycles that make a press "long" (> DEBOUNCE_P).
- AUTO_SHUTDOWN_T, 30000, consecutive IR-inactive cycles before an auto-mode lamp turns off (>=2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- push_button  in  N_CH  raw, asynchronous push buttons, 1 = pressed
- infravermelho  in  N_CH  raw, asynchronous IR sensors, 1 = presence
- saida  out  N_CH  lamp drive, 1 = on
- led  out  N_CH  mode indicator, 1 = manual mode
- desligou  out  N_CH  one-cycle pulse when auto timeout switches a lamp off

Behaviour:
- Channels are fully independent; no shared state between channels.
- Reset (rst_n=0, asynchronous):
  - all FSMs go to their initial states and all counters clear;
  - saida=0, led=0, desligou=0;
  - synchronizer flops clear to 0.
- Reset mid-operation discards any press or timeout in progress.

Input conditioning:
- push_button[i] and infravermelho[i] each pass through a 2-flop synchronizer.
- Only synchronized signals are used downstream.
- Debounce, per channel:
  - counter increments while pb_s != pb_db and clears when they are equal;
  - when the counter reaches DEBOUNCE_P-1 while still different, pb_db takes pb_s on the next edge.
  - pb_db therefore follows a stable raw change after DEBOUNCE_P+2 cycles.
  - A glitch shorter than DEBOUNCE_P cycles never changes pb_db.
- IR is not debounced.

Press classifier FSM (per channel), states B_IDLE, B_HOLD, B_WAIT_REL:
- B_IDLE:
  - on pb_db rising, go to B_HOLD with hold_cnt=0.
- B_HOLD:
  - hold_cnt increments each cycle;
  - if hold_cnt==SWITCH_MODE_MIN_T-1 with pb_db=1, register curto=0 and longo=1 (one cycle), then go to B_WAIT_REL;
  - if pb_db falls first, register curto=1 (one cycle), then go to B_IDLE.
- B_WAIT_REL:
  - go to B_IDLE when pb_db=0; no further pulses.

Lamp FSM (per channel), states DES_AUTO (reset), LIG_AUTO, DES_MAN, LIG_MAN:
- Priority within a cycle: longo > curto > IR/timeout.
- longo:
  - from either auto state, go to DES_MAN;
  - from either manual state, go to DES_AUTO and clear idle_cnt.
- curto:
  - DES_MAN <-> LIG_MAN;
  - ignored in auto states.
- DES_AUTO:
  - ir_s=1 -> LIG_AUTO with idle_cnt=0.
- LIG_AUTO:
  - ir_s=1 clears idle_cnt;
  - ir_s=0 increments idle_cnt;
  - when idle_cnt==AUTO_SHUTDOWN_T-1 with ir_s=0: go to DES_AUTO and pulse desligou for one cycle;
  - if IR returns in that same cycle, there is no timeout.
- Manual states ignore IR, and idle_cnt is held at 0.

Output decode:
- Outputs decode directly from the lamp state register, as in the current controller:
  - saida=1 in LIG_*;
  - led=1 in *_MAN.
- desligou is registered.

Latencies:
- raw IR rise -> saida=1: 3 cycles.
- raw IR fall -> saida=0: AUTO_SHUTDOWN_T+2 cycles.
- raw release of a short press -> manual saida toggle: DEBOUNCE_P+4 cycles.

Width rules:
- Counter widths are $clog2(param+1).
- Counters saturate and never wrap.

Decomposition:
- Package controladora_pkg holds:
  - typedef enum estado_lampada_t {DES_AUTO, LIG_AUTO, DES_MAN, LIG_MAN};
  - typedef enum estado_botao_t {B_IDLE, B_HOLD, B_WAIT_REL}.
- Sub-module canal_lampada holds one channel (synchronizers, debounce, classifier, lamp FSM).
- The top level instantiates N_CH copies in a generate loop.

Test Plan:
All scenarios use N_CH=2, DEBOUNCE_P=4, SWITCH_MODE_MIN_T=20, AUTO_SHUTDOWN_T=16.
- Reset: rst_n=0 asserted mid-simulation with lamps on -> saida=00, led=00, desligou=00 immediately (asynchronous); after release, raw IR0 1 -> saida[0]=1 exactly 3 cycles later.
- Auto timeout: IR0 high 10 cycles, then low -> saida[0] falls 18 cycles after the raw fall; desligou[0] pulses exactly once; channel 1 unaffected.
- IR retrigger: IR0 drops for 10 cycles, pulses high 1 cycle, drops again -> timeout measured from the second fall; no desligou at the first.
- Long press: PB1 held 40 cycles -> led[1]=1 and saida[1]=0 after 2+4+20+2 cycles; release produces no extra toggle.
- Short press in manual: PB1 held 8 cycles, then released -> saida[1] toggles 0->1 at 8 cycles after the raw release; a second short press gives 1->0; a short press in auto mode gives no change.
- Bounce rejection: PB0 toggling every 2 cycles for 30 cycles -> no pulses and no state change on any channel.
